// File: rtl/serial_pkg.sv
// serial_pkg: types and constants shared by the serializer and the serial
// pattern-detector path (state encoding, counter width, bench defaults).
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_t;

    localparam int   SER_WIDTH_DEFAULT    = 8;
    localparam logic SER_IDLE_BIT_DEFAULT = 1'b0;
    localparam int   SER_CNT_W            = $clog2(SER_WIDTH_DEFAULT + 1);

endpackage

// File: rtl/ser_hold_reg.sv
// ser_hold_reg: one-entry holding register in front of the shifter.
// A word accepted while the shifter is busy parks here until the shifter
// finishes its current frame and pops it; load_ready is simply !hold_full.
module ser_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    input  logic             bypass,
    input  logic             pop,
    output logic             load_ready,
    output logic             hold_full,
    output logic [WIDTH-1:0] hold_data
);

    logic accept;

    assign load_ready = !hold_full;
    assign accept     = load_valid && load_ready;

    // Capture a word that cannot go straight into the shifter; pop and accept never coincide since ready is low while full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (pop) begin
            hold_full <= 1'b0;
        end else if (accept && !bypass) begin
            hold_data <= load_data;
            hold_full <= 1'b1;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end, MSB first, one bit per clock.
// Build option BIT_SERIALIZER_PARITY_EN appends an even-parity bit per word.
// Outputs toward the detector are decoded from registered state only.
module bit_serializer
    import serial_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    ser_state_t       state;
    logic [WIDTH-1:0] sh;
    logic [CNT_W-1:0] cnt;
    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic             accept;
    logic             frame_end;
    logic             shifter_free;
    logic             pop;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             par;
`endif

    ser_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk        (clk),
        .rst        (rst),
        .load_data  (load_data),
        .load_valid (load_valid),
        .bypass     (shifter_free),
        .pop        (pop),
        .load_ready (load_ready),
        .hold_full  (hold_full),
        .hold_data  (hold_data)
    );

    assign accept = load_valid && load_ready;

`ifdef BIT_SERIALIZER_PARITY_EN
    assign frame_end = (state == PARITY);
`else
    assign frame_end = (state == SHIFT) && (cnt == '0);
`endif

    assign shifter_free = (state == IDLE) || (frame_end && !hold_full);
    assign pop          = frame_end && hold_full;
    assign busy         = (state != IDLE) || hold_full;

    // Frame sequencing: refill from hold or bypass a new word at frame end, otherwise shift down to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
`ifdef BIT_SERIALIZER_PARITY_EN
            par   <= 1'b0;
`endif
        end else if (pop) begin
            state <= SHIFT;
            sh    <= hold_data;
            cnt   <= CNT_W'(WIDTH - 1);
`ifdef BIT_SERIALIZER_PARITY_EN
            par   <= ^hold_data;
`endif
        end else if (accept && shifter_free) begin
            state <= SHIFT;
            sh    <= load_data;
            cnt   <= CNT_W'(WIDTH - 1);
`ifdef BIT_SERIALIZER_PARITY_EN
            par   <= ^load_data;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    sh <= sh << 1;
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
                        state <= PARITY;
`else
                        state <= IDLE;
`endif
                    end
                end
`ifdef BIT_SERIALIZER_PARITY_EN
                PARITY: state <= IDLE;
`endif
                default: ;
            endcase
        end
    end

    // Stream outputs decoded purely from the registered FSM, shifter and counter
    always_comb begin
        ser_out   = IDLE_BIT;
        ser_valid = 1'b0;
        word_done = 1'b0;
        case (state)
            SHIFT: begin
                ser_out   = sh[WIDTH-1];
                ser_valid = 1'b1;
`ifndef BIT_SERIALIZER_PARITY_EN
                word_done = (cnt == '0);
`endif
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            PARITY: begin
                ser_out   = par;
                ser_valid = 1'b1;
                word_done = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: self-checking bench for bit_serializer.
// The reference model is a queue of accepted words: the head word is the one
// on the wire, a second entry means the holding register is occupied.
`timescale 1ns/1ps
module tb_bit_serializer;
    import serial_pkg::*;

    localparam int   WIDTH    = SER_WIDTH_DEFAULT;
    localparam logic IDLE_BIT = SER_IDLE_BIT_DEFAULT;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int   FL       = WIDTH + 1;
`else
    localparam int   FL       = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             word_done;
    logic             busy;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [WIDTH-1:0] mq[$];
    int               fidx = 0;
    logic             accepted;
    logic             exp_out, exp_valid, exp_done, exp_ready, exp_busy;

    bit_serializer #(.WIDTH(WIDTH), .IDLE_BIT(IDLE_BIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .word_done  (word_done),
        .busy       (busy)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    task automatic calc_exp();
        logic [WIDTH-1:0] w;
        exp_ready = (mq.size() < 2);
        exp_busy  = (mq.size() > 0);
        exp_valid = (mq.size() > 0);
        exp_out   = IDLE_BIT;
        exp_done  = 1'b0;
        if (mq.size() > 0) begin
            w = mq[0];
            exp_out  = (fidx < WIDTH) ? w[WIDTH-1-fidx] : ^w;
            exp_done = (fidx == FL - 1);
        end
    endtask

    task automatic tick();
        logic acc;
        acc = load_valid && (mq.size() < 2);
        @(posedge clk);
        if (mq.size() > 0) begin
            fidx++;
            if (fidx == FL) begin
                mq.delete(0);
                fidx = 0;
            end
        end
        if (acc) mq.push_back(load_data);
        accepted = acc;
        @(negedge clk);
        calc_exp();
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({ser_out, ser_valid, word_done, load_ready, busy} !== {IDLE_BIT, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: out/valid/done/ready/busy=%b required %b",
                     {ser_out, ser_valid, word_done, load_ready, busy}, {IDLE_BIT, 1'b0, 1'b0, 1'b1, 1'b0});
        end
        rst = 1'b0;
        mq.delete();
        fidx = 0;
        calc_exp();
        @(negedge clk);
    endtask

    task automatic test_single_word();
        logic [WIDTH-1:0] ref_word;
        ref_word   = 8'hD0;
        load_data  = ref_word;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int k = 1; k <= FL + 1; k++) begin
            tests_run++;
            if ({ser_out, ser_valid, word_done, load_ready, busy} !== {exp_out, exp_valid, exp_done, exp_ready, exp_busy}) begin
                tests_failed++;
                $display("[TB] FAIL single_word cycle %0d: out/valid/done/ready/busy=%b required %b", k,
                         {ser_out, ser_valid, word_done, load_ready, busy}, {exp_out, exp_valid, exp_done, exp_ready, exp_busy});
            end
            if (k <= WIDTH) begin
                tests_run++;
                if (ser_out !== ref_word[WIDTH-k]) begin
                    tests_failed++;
                    $display("[TB] FAIL single_word_bit %0d: got %b required %b", k, ser_out, ref_word[WIDTH-k]);
                end
            end
            tests_run++;
            if (word_done !== (k == FL)) begin
                tests_failed++;
                $display("[TB] FAIL single_word_done cycle %0d: got %b required %b", k, word_done, (k == FL));
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] words [3];
        int n = 0, run = 0, best = 0, dones = 0;
        bit saw_low = 1'b0;
        words[0] = 8'hFF;
        words[1] = 8'h00;
        words[2] = 8'hA5;
        load_data  = words[0];
        load_valid = 1'b1;
        for (int c = 0; c < 3 * FL + 4; c++) begin
            tick();
            if (accepted) begin
                n++;
                if (n < 3) load_data = words[n];
                else load_valid = 1'b0;
            end
            tests_run++;
            if ({ser_out, ser_valid, word_done, load_ready, busy} !== {exp_out, exp_valid, exp_done, exp_ready, exp_busy}) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back cycle %0d: out/valid/done/ready/busy=%b required %b", c,
                         {ser_out, ser_valid, word_done, load_ready, busy}, {exp_out, exp_valid, exp_done, exp_ready, exp_busy});
            end
            if (ser_valid === 1'b1) begin
                run++;
                if (run > best) best = run;
            end else begin
                run = 0;
            end
            if (word_done === 1'b1) dones++;
            if (load_ready === 1'b0) saw_low = 1'b1;
        end
        load_valid = 1'b0;
        tests_run++;
        if (best != 3 * FL) begin
            tests_failed++;
            $display("[TB] FAIL back_to_back_run: got %0d valid cycles required %0d", best, 3 * FL);
        end
        tests_run++;
        if (dones != 3) begin
            tests_failed++;
            $display("[TB] FAIL back_to_back_done_count: got %0d required 3", dones);
        end
        tests_run++;
        if (!saw_low) begin
            tests_failed++;
            $display("[TB] FAIL back_to_back_ready_drop: got never-low required low while hold full");
        end
    endtask

    task automatic test_stall();
        for (int w = 0; w < 2; w++) begin
            load_data  = WIDTH'($urandom);
            load_valid = 1'b1;
            tick();
            load_valid = 1'b0;
            for (int c = 0; c < FL + 5; c++) begin
                tests_run++;
                if ({ser_out, ser_valid, word_done, load_ready, busy} !== {exp_out, exp_valid, exp_done, exp_ready, exp_busy}) begin
                    tests_failed++;
                    $display("[TB] FAIL stall word %0d cycle %0d: out/valid/done/ready/busy=%b required %b", w, c,
                             {ser_out, ser_valid, word_done, load_ready, busy}, {exp_out, exp_valid, exp_done, exp_ready, exp_busy});
                end
                if (mq.size() == 0) begin
                    tests_run++;
                    if ({ser_out, ser_valid, busy} !== {IDLE_BIT, 1'b0, 1'b0}) begin
                        tests_failed++;
                        $display("[TB] FAIL stall_idle cycle %0d: out/valid/busy=%b required %b", c,
                                 {ser_out, ser_valid, busy}, {IDLE_BIT, 1'b0, 1'b0});
                    end
                end
                tick();
            end
        end
    endtask

    task automatic test_reset_mid_word();
        logic [WIDTH-1:0] nw;
        load_data  = 8'h96;
        load_valid = 1'b1;
        tick();
        load_data = WIDTH'($urandom);
        for (int c = 0; c < 3; c++) begin
            tests_run++;
            if ({ser_out, ser_valid, word_done, load_ready, busy} !== {exp_out, exp_valid, exp_done, exp_ready, exp_busy}) begin
                tests_failed++;
                $display("[TB] FAIL reset_mid_pre cycle %0d: out/valid/done/ready/busy=%b required %b", c,
                         {ser_out, ser_valid, word_done, load_ready, busy}, {exp_out, exp_valid, exp_done, exp_ready, exp_busy});
            end
            tick();
            load_valid = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({ser_out, ser_valid, word_done, load_ready, busy} !== {IDLE_BIT, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_async: out/valid/done/ready/busy=%b required %b",
                     {ser_out, ser_valid, word_done, load_ready, busy}, {IDLE_BIT, 1'b0, 1'b0, 1'b1, 1'b0});
        end
        mq.delete();
        fidx = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        calc_exp();
        for (int c = 0; c < 3; c++) begin
            tests_run++;
            if ({ser_out, ser_valid, word_done, load_ready, busy} !== {exp_out, exp_valid, exp_done, exp_ready, exp_busy}) begin
                tests_failed++;
                $display("[TB] FAIL reset_mid_quiet cycle %0d: out/valid/done/ready/busy=%b required %b", c,
                         {ser_out, ser_valid, word_done, load_ready, busy}, {exp_out, exp_valid, exp_done, exp_ready, exp_busy});
            end
            tick();
        end
        nw         = WIDTH'($urandom);
        load_data  = nw;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        tests_run++;
        if ({ser_valid, ser_out} !== {1'b1, nw[WIDTH-1]}) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_restart_msb: valid/out=%b required %b", {ser_valid, ser_out}, {1'b1, nw[WIDTH-1]});
        end
        for (int c = 0; c < FL + 1; c++) begin
            tests_run++;
            if ({ser_out, ser_valid, word_done, load_ready, busy} !== {exp_out, exp_valid, exp_done, exp_ready, exp_busy}) begin
                tests_failed++;
                $display("[TB] FAIL reset_mid_restart cycle %0d: out/valid/done/ready/busy=%b required %b", c,
                         {ser_out, ser_valid, word_done, load_ready, busy}, {exp_out, exp_valid, exp_done, exp_ready, exp_busy});
            end
            tick();
        end
    endtask

    task automatic test_hold_change();
        int lowc = 0;
        load_data  = WIDTH'($urandom);
        load_valid = 1'b1;
        tick();
        load_data = WIDTH'($urandom);
        tick();
        load_data = WIDTH'($urandom);
        for (int c = 0; c < 4 * FL; c++) begin
            tests_run++;
            if ({ser_out, ser_valid, word_done, load_ready, busy} !== {exp_out, exp_valid, exp_done, exp_ready, exp_busy}) begin
                tests_failed++;
                $display("[TB] FAIL hold_change cycle %0d: out/valid/done/ready/busy=%b required %b", c,
                         {ser_out, ser_valid, word_done, load_ready, busy}, {exp_out, exp_valid, exp_done, exp_ready, exp_busy});
            end
            if (load_ready === 1'b0) lowc++;
            tick();
            if (load_valid && accepted) load_valid = 1'b0;
            else if (load_valid) load_data = WIDTH'($urandom);
        end
        load_valid = 1'b0;
        tests_run++;
        if (lowc == 0) begin
            tests_failed++;
            $display("[TB] FAIL hold_change_ready_low: got 0 not-ready cycles required at least 1");
        end
    endtask

`ifdef BIT_SERIALIZER_PARITY_EN
    task automatic test_parity();
        logic [8:0] seq;
        seq        = 9'b0_0001_0111;
        load_data  = 8'h0B;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tests_run++;
            if ({ser_out, ser_valid, word_done} !== {seq[9-k], 1'b1, (k == 9)}) begin
                tests_failed++;
                $display("[TB] FAIL parity_0b cycle %0d: out/valid/done=%b required %b", k,
                         {ser_out, ser_valid, word_done}, {seq[9-k], 1'b1, (k == 9)});
            end
            tick();
        end
        load_data  = 8'h03;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k == 9) begin
                tests_run++;
                if ({ser_out, ser_valid, word_done} !== {1'b0, 1'b1, 1'b1}) begin
                    tests_failed++;
                    $display("[TB] FAIL parity_03_bit: out/valid/done=%b required 011", {ser_out, ser_valid, word_done});
                end
            end
            tick();
        end
    endtask
`endif

    task automatic test_random();
        load_valid = 1'b0;
        for (int c = 0; c < 400 + 2 * FL; c++) begin
            if (c < 400 && !load_valid && $urandom_range(0, 2) != 0) begin
                load_data  = WIDTH'($urandom);
                load_valid = 1'b1;
            end
            tick();
            if (accepted) load_valid = 1'b0;
            tests_run++;
            if ({ser_out, ser_valid, word_done, load_ready, busy} !== {exp_out, exp_valid, exp_done, exp_ready, exp_busy}) begin
                tests_failed++;
                $display("[TB] FAIL random cycle %0d: out/valid/done/ready/busy=%b required %b", c,
                         {ser_out, ser_valid, word_done, load_ready, busy}, {exp_out, exp_valid, exp_done, exp_ready, exp_busy});
            end
        end
        load_valid = 1'b0;
    endtask

    // Scenario sequence followed by the single summary line
    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_reset_mid_word();
        test_hold_change();
`ifdef BIT_SERIALIZER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
